regfile_writeback_queue: RTL

- Writer-side front end for the 4 x 8 CPU register file.
- Accepts register-write requests from two producers, the ALU and the load unit, over valid/ready handshakes, and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the register file's single write port (write_enable, reg_write, write_data).
- Keeps a per-register pending scoreboard so decode can stall on outstanding writes.

---
 rtl/regfile_writeback_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the register file: two producers, in-order FIFO, per-register pending scoreboard.
// Optional macro WB_FORWARD_EN adds a youngest-entry forwarding lookup (fwd_reg/fwd_hit/fwd_data).
module regfile_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int DW    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [AW-1:0]         alu_reg,
   input  logic [DW-1:0]         alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [AW-1:0]         mem_reg,
   input  logic [DW-1:0]         mem_data,
   input  logic                  wb_hold,
   output logic                  write_enable,
   output logic [AW-1:0]         reg_write,
   output logic [DW-1:0]         write_data,
   output logic [(2**AW)-1:0]    pending,
   output logic                  full,
   output logic                  empty
`ifdef WB_FORWARD_EN
   ,
   input  logic [AW-1:0]         fwd_reg,
   output logic                  fwd_hit,
   output logic [DW-1:0]         fwd_data
`endif
);

   localparam int IW   = $clog2(DEPTH);
   localparam int PW   = IW + 1;
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int NREG = 2 ** AW;

   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW-1:0] PTR_MSB = {1'b1, {IW{1'b0}}};
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q [NREG];
   logic [CW-1:0]   cnt_d [NREG];
   logic [NREG-1:0] pending_q, pending_d;

   // Entry storage carries no reset; only pointers and counters define validity.
   logic [AW-1:0]   reg_mem_q  [DEPTH];
   logic [DW-1:0]   data_mem_q [DEPTH];

   logic            full_c, empty_c;
   logic            mem_take, alu_take, push, pop;
   logic [AW-1:0]   push_reg, head_reg;
   logic [DW-1:0]   push_data, head_data;
   logic [IW-1:0]   wr_idx, rd_idx;

   always_comb begin
      empty_c   = (wr_ptr_q == rd_ptr_q);
      full_c    = ((wr_ptr_q ^ rd_ptr_q) == PTR_MSB);
      mem_take  = mem_valid && !full_c;
      alu_take  = alu_valid && !full_c && !mem_valid;
      push      = mem_take || alu_take;
      push_reg  = mem_take ? mem_reg  : alu_reg;
      push_data = mem_take ? mem_data : alu_data;
      wr_idx    = wr_ptr_q[IW-1:0];
      rd_idx    = rd_ptr_q[IW-1:0];
      head_reg  = reg_mem_q[rd_idx];
      head_data = data_mem_q[rd_idx];
      // Suppressing the pop during reset keeps the register file from committing a discarded entry.
      pop       = !empty_c && !wb_hold && !reset;
      wr_ptr_d  = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d  = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
   end

   always_comb begin
      pending_d = '0;
      for (int i = 0; i < NREG; i++) begin
         logic inc, dec;
         inc      = push && (push_reg == AW'(i));
         dec      = pop  && (head_reg == AW'(i));
         cnt_d[i] = cnt_q[i];
         if (inc && !dec)
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         else if (dec && !inc)
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         pending_d[i] = (cnt_d[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pending_q <= '0;
         for (int i = 0; i < NREG; i++)
            cnt_q[i] <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pending_q <= pending_d;
         for (int i = 0; i < NREG; i++)
            cnt_q[i] <= cnt_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         reg_mem_q[wr_idx]  <= push_reg;
         data_mem_q[wr_idx] <= push_data;
      end
   end

   always_comb begin
      mem_ready    = !full_c;
      alu_ready    = !full_c && !mem_valid;
      write_enable = pop;
      reg_write    = empty_c ? '0 : head_reg;
      write_data   = empty_c ? '0 : head_data;
      pending      = pending_q;
      full         = full_c;
      empty        = empty_c;
   end

`ifdef WB_FORWARD_EN
   logic [PW-1:0] occ;
   logic [IW-1:0] fwd_idx;

   // Walk head to tail so the last match seen is the youngest write to fwd_reg.
   always_comb begin
      occ      = wr_ptr_q - rd_ptr_q;
      fwd_idx  = '0;
      fwd_hit  = pending_q[fwd_reg];
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_idx + IW'(k);
         if ((PW'(k) < occ) && (reg_mem_q[fwd_idx] == fwd_reg))
            fwd_data = data_mem_q[fwd_idx];
      end
   end
`endif

endmodule
